vga_line_fetch_ctrl: RTL and testbench

// Sequences pixel-line fills of the ping-pong VGA line buffer. The VGALineBuffer AXI4-Lite registers configure it.

---
 rtl/vga_lb_pkg.sv | 24 ++
 rtl/vga_line_fetch_ctrl_if.sv | 22 ++
 rtl/vga_lb_addr_gen.sv | 43 ++++
 rtl/vga_line_fetch_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_vga_line_fetch_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_lb_pkg.sv
// Shared types and default widths for the VGA line-buffer fetch controller.
package vga_lb_pkg;

    localparam int ADDR_W = 32;
    localparam int HPIX_W = 12;
    localparam int VLIN_W = 11;
    localparam int UCNT_W = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        FETCH      = 3'd2,
        WAIT_DONE  = 3'd3,
        WAIT_LINE  = 3'd4
    } lf_state_e;

    typedef logic [0:0] bank_t;

    // A fill is in flight from request until its completion pulse.
    function automatic logic is_fill_state(input lf_state_e s);
        return (s == FETCH) || (s == WAIT_DONE);
    endfunction

endpackage

// File: rtl/vga_line_fetch_ctrl_if.sv
// Fill request / completion handshake between the fetch controller and the line-buffer write engine.
interface vga_line_fetch_ctrl_if #(
    parameter int ADDR_W = vga_lb_pkg::ADDR_W,
    parameter int HPIX_W = vga_lb_pkg::HPIX_W
);
    logic              fetch_req;
    logic              fetch_ack;
    logic [ADDR_W-1:0] fetch_addr;
    logic [HPIX_W-1:0] fetch_len;
    logic              fetch_bank;
    logic              fetch_done;

    modport master (
        output fetch_req, fetch_addr, fetch_len, fetch_bank,
        input  fetch_ack, fetch_done
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_len, fetch_bank,
        output fetch_ack, fetch_done
    );
endinterface

// File: rtl/vga_lb_addr_gen.sv
// Line start address accumulator: load captures base and stride, step adds the stride (wraps mod 2^ADDR_W).
module vga_lb_addr_gen #(
    parameter int ADDR_W = vga_lb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_stride,
    input  logic              step,
    output logic [ADDR_W-1:0] acc
);
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0] stride_q, stride_d;

    // Next accumulator and stride shadow.
    always_comb begin
        acc_d    = acc_q;
        stride_d = stride_q;
        if (load) begin
            acc_d    = load_base;
            stride_d = load_stride;
        end else if (step) begin
            acc_d = acc_q + stride_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= {ADDR_W{1'b0}};
            stride_q <= {ADDR_W{1'b0}};
        end else begin
            acc_q    <= acc_d;
            stride_q <= stride_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/vga_line_fetch_ctrl.sv
// Sequences ping-pong line-buffer fills against VGA timing: one fill per active line, bank swap
// on each line start, underrun pulses when a fill is still in flight as its line begins.
module vga_line_fetch_ctrl #(
    parameter int ADDR_W = vga_lb_pkg::ADDR_W,
    parameter int HPIX_W = vga_lb_pkg::HPIX_W,
    parameter int VLIN_W = vga_lb_pkg::VLIN_W,
    parameter int UCNT_W = vga_lb_pkg::UCNT_W
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cfg_enable,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [ADDR_W-1:0]     cfg_stride,
    input  logic [HPIX_W-1:0]     cfg_h_active,
    input  logic [VLIN_W-1:0]     cfg_v_active,
    input  logic                  vga_frame_start,
    input  logic                  vga_line_start,
    vga_line_fetch_ctrl_if.master fetch,
    output logic                  disp_bank,
    output logic [VLIN_W-1:0]     line_idx,
    output logic                  underrun,
    output logic [UCNT_W-1:0]     underrun_cnt,
    output logic                  busy
);
    import vga_lb_pkg::*;

    lf_state_e         state_q, state_d;
    logic              fetch_req_q, fetch_req_d;
    logic              busy_q, busy_d;
    logic [HPIX_W-1:0] h_q, h_d;
    logic [VLIN_W-1:0] v_q, v_d;
    logic [VLIN_W-1:0] fill_idx_q, fill_idx_d;
    logic [VLIN_W-1:0] line_idx_q, line_idx_d;
    bank_t             fill_bank_q, fill_bank_d;
    bank_t             disp_bank_q, disp_bank_d;
    logic              underrun_q, underrun_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;
    logic              restart_pend_q, restart_pend_d;
    logic              line_pend_q, line_pend_d;
    logic [ADDR_W-1:0] acc_s;

    logic ls_s, in_fill_s, ack_s, done_s, cfg_zero_s, more_s;
    logic frame_act_s, swap_act_s, step_s, underrun_ev_s;

    // Frame start masks a coincident line start.
    assign ls_s          = vga_line_start & ~vga_frame_start;
    assign in_fill_s     = is_fill_state(state_q);
    assign ack_s         = (state_q == FETCH) & fetch.fetch_ack;
    assign done_s        = (state_q == WAIT_DONE) & fetch.fetch_done;
    assign cfg_zero_s    = (cfg_h_active == {HPIX_W{1'b0}}) | (cfg_v_active == {VLIN_W{1'b0}});
    assign more_s        = ({1'b0, fill_idx_q} + {{VLIN_W{1'b0}}, 1'b1}) < {1'b0, v_q};
    assign underrun_ev_s = ls_s & in_fill_s;
    // A deferred restart or late line start is serviced on the completion of the fill in flight.
    assign frame_act_s   = cfg_enable &
                           ((vga_frame_start & ((state_q == WAIT_FRAME) | (state_q == WAIT_LINE))) |
                            (done_s & (restart_pend_q | vga_frame_start)));
    assign swap_act_s    = cfg_enable & ~frame_act_s &
                           ((ls_s & (state_q == WAIT_LINE)) | (done_s & (line_pend_q | ls_s)));
    assign step_s        = swap_act_s & more_s;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = cfg_enable ? WAIT_FRAME : IDLE;
            FETCH: begin
                // An unaccepted request is withdrawn on disable; an accepted one is completed.
                if (ack_s)            state_d = WAIT_DONE;
                else if (!cfg_enable) state_d = IDLE;
                else                  state_d = FETCH;
            end
            WAIT_FRAME, WAIT_DONE, WAIT_LINE: begin
                if ((state_q == WAIT_DONE) && !done_s) state_d = WAIT_DONE;
                else if (!cfg_enable)                  state_d = IDLE;
                else if (frame_act_s)                  state_d = cfg_zero_s ? WAIT_FRAME : FETCH;
                else if (swap_act_s)                   state_d = more_s ? FETCH : WAIT_FRAME;
                else if (state_q == WAIT_DONE)         state_d = WAIT_LINE;
                else                                   state_d = state_q;
            end
            default:    state_d = IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        fetch_req_d    = (state_d == FETCH);
        busy_d         = (state_d != IDLE);
        underrun_d     = underrun_ev_s;
        h_d            = h_q;
        v_d            = v_q;
        fill_idx_d     = fill_idx_q;
        line_idx_d     = line_idx_q;
        fill_bank_d    = fill_bank_q;
        disp_bank_d    = disp_bank_q;
        ucnt_d         = ucnt_q;
        restart_pend_d = restart_pend_q;
        line_pend_d    = line_pend_q;
        if (frame_act_s) begin
            h_d            = cfg_h_active;
            v_d            = cfg_v_active;
            fill_idx_d     = {VLIN_W{1'b0}};
            line_idx_d     = {VLIN_W{1'b0}};
            fill_bank_d    = 1'b0;
            ucnt_d         = {UCNT_W{1'b0}};
            restart_pend_d = 1'b0;
            line_pend_d    = 1'b0;
        end else begin
            if (underrun_ev_s && (ucnt_q != {UCNT_W{1'b1}})) begin
                ucnt_d = ucnt_q + {{(UCNT_W-1){1'b0}}, 1'b1};
            end else begin
                ucnt_d = ucnt_q;
            end
            if (swap_act_s) begin
                disp_bank_d = fill_bank_q;
                line_idx_d  = fill_idx_q;
                line_pend_d = 1'b0;
            end else if (underrun_ev_s) begin
                line_pend_d = 1'b1;
            end else begin
                line_pend_d = line_pend_q;
            end
            if (step_s) begin
                fill_bank_d = ~fill_bank_q;
                fill_idx_d  = fill_idx_q + {{(VLIN_W-1){1'b0}}, 1'b1};
            end else begin
                fill_bank_d = fill_bank_q;
                fill_idx_d  = fill_idx_q;
            end
            if (vga_frame_start && in_fill_s && !done_s) begin
                restart_pend_d = 1'b1;
            end else begin
                restart_pend_d = restart_pend_q;
            end
        end
        restart_pend_d = (state_d == IDLE) ? 1'b0 : restart_pend_d;
        line_pend_d    = (state_d == IDLE) ? 1'b0 : line_pend_d;
    end

    // State and output registers.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q        <= IDLE;
            fetch_req_q    <= 1'b0;
            busy_q         <= 1'b0;
            h_q            <= {HPIX_W{1'b0}};
            v_q            <= {VLIN_W{1'b0}};
            fill_idx_q     <= {VLIN_W{1'b0}};
            line_idx_q     <= {VLIN_W{1'b0}};
            fill_bank_q    <= 1'b0;
            disp_bank_q    <= 1'b0;
            underrun_q     <= 1'b0;
            ucnt_q         <= {UCNT_W{1'b0}};
            restart_pend_q <= 1'b0;
            line_pend_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_req_q    <= fetch_req_d;
            busy_q         <= busy_d;
            h_q            <= h_d;
            v_q            <= v_d;
            fill_idx_q     <= fill_idx_d;
            line_idx_q     <= line_idx_d;
            fill_bank_q    <= fill_bank_d;
            disp_bank_q    <= disp_bank_d;
            underrun_q     <= underrun_d;
            ucnt_q         <= ucnt_d;
            restart_pend_q <= restart_pend_d;
            line_pend_q    <= line_pend_d;
        end
    end

    vga_lb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .load        (frame_act_s),
        .load_base   (cfg_base_addr),
        .load_stride (cfg_stride),
        .step        (step_s),
        .acc         (acc_s)
    );

    assign fetch.fetch_req  = fetch_req_q;
    assign fetch.fetch_addr = acc_s;
    assign fetch.fetch_len  = h_q;
    assign fetch.fetch_bank = fill_bank_q;
    assign disp_bank        = disp_bank_q;
    assign line_idx         = line_idx_q;
    assign underrun         = underrun_q;
    assign underrun_cnt     = ucnt_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Directed bench for vga_line_fetch_ctrl with a simple delayed-completion fetch engine model.
module tb_vga_line_fetch_ctrl;

    logic        aclk;
    logic        aresetn;
    logic        cfg_enable;
    logic [31:0] cfg_base;
    logic [31:0] cfg_stride;
    logic [11:0] cfg_h;
    logic [10:0] cfg_v;
    logic        fs;
    logic        ls;
    logic        disp_bank;
    logic [10:0] line_idx;
    logic        underrun;
    logic [15:0] ucnt;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    vga_line_fetch_ctrl_if #(.ADDR_W(32), .HPIX_W(12)) fif ();

    vga_line_fetch_ctrl dut (
        .ACLK            (aclk),
        .ARESETN         (aresetn),
        .cfg_enable      (cfg_enable),
        .cfg_base_addr   (cfg_base),
        .cfg_stride      (cfg_stride),
        .cfg_h_active    (cfg_h),
        .cfg_v_active    (cfg_v),
        .vga_frame_start (fs),
        .vga_line_start  (ls),
        .fetch           (fif),
        .disp_bank       (disp_bank),
        .line_idx        (line_idx),
        .underrun        (underrun),
        .underrun_cnt    (ucnt),
        .busy            (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Transfer log and request / underrun counters.
    int          xfer_n    = 0;
    int          req_hi_n  = 0;
    int          ur_n      = 0;
    logic [31:0] xa [64];
    logic [11:0] xl [64];
    logic        xb [64];

    always @(posedge aclk) begin
        if (fif.fetch_req && fif.fetch_ack) begin
            if (xfer_n < 64) begin
                xa[xfer_n] = fif.fetch_addr;
                xl[xfer_n] = fif.fetch_len;
                xb[xfer_n] = fif.fetch_bank;
            end
            xfer_n++;
        end
        if (fif.fetch_req) req_hi_n++;
    end

    always @(negedge aclk) begin
        if (underrun) ur_n++;
    end

    // Fetch engine model: fetch_done is seen done_delay cycles after the accepting edge.
    int done_delay = 10;
    int done_cnt   = 0;
    initial begin
        fif.fetch_done = 1'b0;
        forever begin
            @(posedge aclk);
            if (fif.fetch_req && fif.fetch_ack) done_cnt = done_delay;
            else if (done_cnt > 0)              done_cnt--;
            #1 fif.fetch_done = (done_cnt == 1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        cfg_enable    = 1'b0;
        fs            = 1'b0;
        ls            = 1'b0;
        fif.fetch_ack = 1'b0;
        cyc(2);
        aresetn = 1'b1;
        cyc(1);
    endtask

    task automatic set_cfg(input logic [31:0] b, input logic [31:0] s, input logic [11:0] h, input logic [10:0] v);
        cfg_base   = b;
        cfg_stride = s;
        cfg_h      = h;
        cfg_v      = v;
    endtask

    task automatic pulse_fs();
        fs = 1'b1;
        cyc(1);
        fs = 1'b0;
    endtask

    task automatic pulse_ls();
        ls = 1'b1;
        cyc(1);
        ls = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({fif.fetch_req, busy, disp_bank, underrun, line_idx, ucnt, fif.fetch_addr} !== {4'b0000, 11'd0, 16'd0, 32'd0}) begin
            $display("FAIL reset_values: got req=%b busy=%b disp=%b ur=%b idx=%0d cnt=%0d addr=%h, expected all 0",
                     fif.fetch_req, busy, disp_bank, underrun, line_idx, ucnt, fif.fetch_addr);
            tests_failed++;
        end
        set_cfg(32'h0000_1000, 32'h0000_0500, 12'd640, 11'd3);
        cfg_enable = 1'b1;
        cyc(1);
        pulse_fs();
        tests_run++;
        if ({fif.fetch_req, busy, fif.fetch_addr} !== {2'b11, 32'h0000_1000}) begin
            $display("FAIL reset_pre_fetch: got req=%b busy=%b addr=%h, expected 1 1 00001000", fif.fetch_req, busy, fif.fetch_addr);
            tests_failed++;
        end
        cyc(3);
        aresetn = 1'b0;
        cyc(1);
        tests_run++;
        if ({fif.fetch_req, busy, disp_bank, ucnt, fif.fetch_addr} !== {3'b000, 16'd0, 32'd0}) begin
            $display("FAIL reset_mid_fetch: got req=%b busy=%b disp=%b cnt=%0d addr=%h, expected all 0",
                     fif.fetch_req, busy, disp_bank, ucnt, fif.fetch_addr);
            tests_failed++;
        end
        aresetn = 1'b1;
    endtask

    task automatic test_line_sequence();
        logic [31:0] ea [3];
        int          x0;
        int          u0;
        ea = '{32'h0000_1000, 32'h0000_1500, 32'h0000_1A00};
        do_reset();
        set_cfg(32'h0000_1000, 32'h0000_0500, 12'd640, 11'd3);
        cfg_enable    = 1'b1;
        fif.fetch_ack = 1'b1;
        done_delay    = 10;
        cyc(1);
        x0 = xfer_n;
        u0 = ur_n;
        pulse_fs();
        // Mid-frame config changes must stay invisible until the next frame.
        set_cfg(32'hDEAD_0000, 32'h0000_0004, 12'd5, 11'd9);
        for (int i = 0; i < 3; i++) begin
            logic        eb;
            logic [10:0] ei;
            eb = (i == 1);
            ei = 11'(i);
            cyc(199);
            pulse_ls();
            tests_run++;
            if ({disp_bank, line_idx} !== {eb, ei}) begin
                $display("FAIL seq_line%0d: got disp=%b idx=%0d, expected disp=%b idx=%0d", i, disp_bank, line_idx, eb, ei);
                tests_failed++;
            end
        end
        cyc(30);
        tests_run++;
        if (xfer_n - x0 !== 3) begin
            $display("FAIL seq_xfer_count: got %0d, expected 3", xfer_n - x0);
            tests_failed++;
        end
        for (int k = 0; k < 3; k++) begin
            logic ekb;
            ekb = (k == 1);
            tests_run++;
            if ({xa[x0+k], xl[x0+k], xb[x0+k]} !== {ea[k], 12'd640, ekb}) begin
                $display("FAIL seq_xfer%0d: got addr=%h len=%0d bank=%b, expected addr=%h len=640 bank=%b",
                         k, xa[x0+k], xl[x0+k], xb[x0+k], ea[k], ekb);
                tests_failed++;
            end
        end
        tests_run++;
        if ({ur_n - u0, ucnt, fif.fetch_req, busy} !== {32'd0, 16'd0, 1'b0, 1'b1}) begin
            $display("FAIL seq_end: got underruns=%0d cnt=%0d req=%b busy=%b, expected 0 0 0 1", ur_n - u0, ucnt, fif.fetch_req, busy);
            tests_failed++;
        end
    endtask

    task automatic test_underrun();
        int u0;
        int t;
        do_reset();
        set_cfg(32'h0000_1000, 32'h0000_0500, 12'd640, 11'd3);
        cfg_enable    = 1'b1;
        fif.fetch_ack = 1'b1;
        done_delay    = 10;
        cyc(1);
        u0 = ur_n;
        pulse_fs();
        cyc(50);
        done_delay = 300;
        pulse_ls();
        cyc(100);
        pulse_ls();
        tests_run++;
        if ({underrun, ucnt, disp_bank, line_idx} !== {1'b1, 16'd1, 1'b0, 11'd0}) begin
            $display("FAIL ur_pulse: got ur=%b cnt=%0d disp=%b idx=%0d, expected 1 1 0 0", underrun, ucnt, disp_bank, line_idx);
            tests_failed++;
        end
        cyc(1);
        tests_run++;
        if (underrun !== 1'b0) begin
            $display("FAIL ur_one_cycle: got %b, expected 0", underrun);
            tests_failed++;
        end
        done_delay = 10;
        t = 0;
        while (!fif.fetch_done && t < 400) begin
            cyc(1);
            t++;
        end
        tests_run++;
        if (t >= 400 || disp_bank !== 1'b0) begin
            $display("FAIL ur_late_done: got waited=%0d disp=%b, expected done before 400 and disp=0", t, disp_bank);
            tests_failed++;
        end
        cyc(1);
        tests_run++;
        if ({disp_bank, line_idx, fif.fetch_req, fif.fetch_bank, fif.fetch_addr} !== {1'b1, 11'd1, 1'b1, 1'b0, 32'h0000_1A00}) begin
            $display("FAIL ur_swap: got disp=%b idx=%0d req=%b bank=%b addr=%h, expected 1 1 1 0 00001a00",
                     disp_bank, line_idx, fif.fetch_req, fif.fetch_bank, fif.fetch_addr);
            tests_failed++;
        end
        cyc(5);
        tests_run++;
        if ({ur_n - u0, ucnt} !== {32'd1, 16'd1}) begin
            $display("FAIL ur_count: got pulses=%0d cnt=%0d, expected 1 1", ur_n - u0, ucnt);
            tests_failed++;
        end
    endtask

    task automatic test_ack_hold();
        int x0;
        int bad;
        do_reset();
        set_cfg(32'h0004_0000, 32'h0000_0100, 12'd320, 11'd2);
        cfg_enable    = 1'b1;
        fif.fetch_ack = 1'b0;
        done_delay    = 10;
        cyc(1);
        x0  = xfer_n;
        bad = 0;
        pulse_fs();
        for (int i = 0; i < 50; i++) begin
            if ({fif.fetch_req, fif.fetch_addr, fif.fetch_len, fif.fetch_bank} !== {1'b1, 32'h0004_0000, 12'd320, 1'b0}) bad++;
            cyc(1);
        end
        tests_run++;
        if (bad !== 0) begin
            $display("FAIL hold_stable: got %0d unstable cycles, expected 0", bad);
            tests_failed++;
        end
        fif.fetch_ack = 1'b1;
        cyc(1);
        fif.fetch_ack = 1'b0;
        tests_run++;
        if (fif.fetch_req !== 1'b0) begin
            $display("FAIL hold_req_drop: got req=%b, expected 0", fif.fetch_req);
            tests_failed++;
        end
        cyc(20);
        tests_run++;
        if ({xfer_n - x0, xa[x0], fif.fetch_req} !== {32'd1, 32'h0004_0000, 1'b0}) begin
            $display("FAIL hold_single_xfer: got count=%0d addr=%h req=%b, expected 1 00040000 0", xfer_n - x0, xa[x0], fif.fetch_req);
            tests_failed++;
        end
    endtask

    task automatic test_restart();
        int bad;
        int t;
        do_reset();
        set_cfg(32'h0000_1000, 32'h0000_0500, 12'd640, 11'd4);
        cfg_enable    = 1'b1;
        fif.fetch_ack = 1'b1;
        done_delay    = 10;
        cyc(1);
        pulse_fs();
        cyc(30);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) done_delay = 40;
            pulse_ls();
            cyc((i == 2) ? 5 : 30);
        end
        tests_run++;
        if ({line_idx, fif.fetch_bank, fif.fetch_addr} !== {11'd2, 1'b1, 32'h0000_1F00}) begin
            $display("FAIL restart_pre: got idx=%0d bank=%b addr=%h, expected 2 1 00001f00", line_idx, fif.fetch_bank, fif.fetch_addr);
            tests_failed++;
        end
        pulse_fs();
        done_delay = 10;
        bad = 0;
        t   = 0;
        while (!fif.fetch_done && t < 100) begin
            if (fif.fetch_req) bad++;
            cyc(1);
            t++;
        end
        tests_run++;
        if (t >= 100 || bad !== 0) begin
            $display("FAIL restart_no_req: got waited=%0d req_cycles=%0d, expected done before 100 and 0 req", t, bad);
            tests_failed++;
        end
        cyc(1);
        tests_run++;
        if ({fif.fetch_req, fif.fetch_addr, fif.fetch_bank, line_idx} !== {1'b1, 32'h0000_1000, 1'b0, 11'd0}) begin
            $display("FAIL restart_req: got req=%b addr=%h bank=%b idx=%0d, expected 1 00001000 0 0",
                     fif.fetch_req, fif.fetch_addr, fif.fetch_bank, line_idx);
            tests_failed++;
        end
    endtask

    task automatic test_zero_and_wrap();
        logic [31:0] ea [3];
        int          r0;
        int          x0;
        ea = '{32'h0000_0020, 32'h0000_0010, 32'h0000_0000};
        do_reset();
        set_cfg(32'h0000_1000, 32'h0000_0500, 12'd640, 11'd0);
        cfg_enable    = 1'b1;
        fif.fetch_ack = 1'b1;
        done_delay    = 10;
        cyc(1);
        r0 = req_hi_n;
        repeat (3) begin
            pulse_fs();
            cyc(30);
        end
        tests_run++;
        if ({req_hi_n - r0, busy} !== {32'd0, 1'b1}) begin
            $display("FAIL zero_v_no_req: got req_cycles=%0d busy=%b, expected 0 1", req_hi_n - r0, busy);
            tests_failed++;
        end
        set_cfg(32'h0000_0020, 32'hFFFF_FFF0, 12'd16, 11'd3);
        x0 = xfer_n;
        pulse_fs();
        repeat (3) begin
            cyc(39);
            pulse_ls();
        end
        cyc(10);
        tests_run++;
        if (xfer_n - x0 !== 3) begin
            $display("FAIL wrap_count: got %0d, expected 3", xfer_n - x0);
            tests_failed++;
        end
        for (int k = 0; k < 3; k++) begin
            logic ekb;
            ekb = (k == 1);
            tests_run++;
            if ({xa[x0+k], xb[x0+k]} !== {ea[k], ekb}) begin
                $display("FAIL wrap_xfer%0d: got addr=%h bank=%b, expected addr=%h bank=%b", k, xa[x0+k], xb[x0+k], ea[k], ekb);
                tests_failed++;
            end
        end
    endtask

    initial begin
        aresetn       = 1'b0;
        cfg_enable    = 1'b0;
        fs            = 1'b0;
        ls            = 1'b0;
        fif.fetch_ack = 1'b0;
        set_cfg(32'd0, 32'd0, 12'd0, 11'd0);
        test_reset();
        test_line_sequence();
        test_underrun();
        test_ack_hold();
        test_restart();
        test_zero_and_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
